rbc_conv_arbiter: RTL

- Shares one Gray-to-binary converter and one binary-to-Gray converter between p_PORTS requesters.
- Each requester submits a code word and a direction bit over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle. The converted result is registered and returned with the requester id.
- Sits between pointer and position producers (counters, encoders) and consumers that need the other code.

---
 rtl/rbc_conv_arbiter_pkg.sv | 15 +
 rtl/rbc_conv_arbiter_codec.sv | 30 +++
 rtl/rbc_conv_arbiter_rr_grant.sv | 53 +++++
 rtl/rbc_conv_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/rbc_conv_arbiter_pkg.sv
// Shared definitions for the reflected-binary-code (Gray) conversion arbiter.
//   DIR_RBC2BIN / DIR_BIN2RBC : meaning of a requester's direction bit.
//   id_width()                : width of a requester index. It is never less
//                               than one bit, so a single-port build still has
//                               a legal id bus.
package rbc_conv_arbiter_pkg;

  localparam logic DIR_RBC2BIN = 1'b0;
  localparam logic DIR_BIN2RBC = 1'b1;

  function automatic int id_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/rbc_conv_arbiter_codec.sv
// Stand-alone Gray (reflected binary code) converters, both purely combinational.
//   rbc2bin : rbc_i [p_WIDTH] -> bin_o [p_WIDTH]   Gray to binary
//   bin2rbc : bin_i [p_WIDTH] -> rbc_o [p_WIDTH]   binary to Gray
module rbc2bin #(
  parameter int p_WIDTH = 4
) (
  input  logic [p_WIDTH-1:0] rbc_i,
  output logic [p_WIDTH-1:0] bin_o
);

  // Binary bit i is the XOR of every Gray bit at position i and above.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < p_WIDTH; i++) begin
      bin_o[i] = ^(rbc_i >> i);
    end
  end

endmodule

module bin2rbc #(
  parameter int p_WIDTH = 4
) (
  input  logic [p_WIDTH-1:0] bin_i,
  output logic [p_WIDTH-1:0] rbc_o
);

  assign rbc_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/rbc_conv_arbiter_rr_grant.sv
// Round-robin priority picker, purely combinational.
//   valid_i [p_PORTS] : requesters asking for service
//   ptr_i   [p_ID_W]  : highest-priority index this cycle
//   en_i              : when low, nothing is granted
//   grant_o [p_PORTS] : one-hot grant, or all zero
//   idx_o   [p_ID_W]  : index of the granted requester (0 when none)
//   any_o             : a grant was issued
module rr_grant #(
  parameter int p_PORTS = 3,
  parameter int p_ID_W  = 2
) (
  input  logic [p_PORTS-1:0] valid_i,
  input  logic [p_ID_W-1:0]  ptr_i,
  input  logic               en_i,
  output logic [p_PORTS-1:0] grant_o,
  output logic [p_ID_W-1:0]  idx_o,
  output logic               any_o
);

  logic found_hi;
  logic found_lo;
  int   hi_idx;
  int   lo_idx;
  int   sel_idx;

  // Two scans replace a modular search: the first valid index at or above
  // the pointer wins; if there is none, the search wraps and the lowest
  // valid index wins.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = 0;
    lo_idx   = 0;
    for (int i = 0; i < p_PORTS; i++) begin
      if (valid_i[i] && !found_lo) begin
        found_lo = 1'b1;
        lo_idx   = i;
      end
      if (valid_i[i] && (i >= int'(ptr_i)) && !found_hi) begin
        found_hi = 1'b1;
        hi_idx   = i;
      end
    end
    sel_idx = found_hi ? hi_idx : lo_idx;
    any_o   = en_i && found_lo;
    idx_o   = any_o ? p_ID_W'(sel_idx) : '0;
    grant_o = '0;
    for (int i = 0; i < p_PORTS; i++) begin
      grant_o[i] = any_o && (sel_idx == i);
    end
  end

endmodule

// File: rtl/rbc_conv_arbiter.sv
// Lets p_PORTS requesters share one Gray->binary and one binary->Gray
// converter. A round-robin arbiter grants at most one request per cycle. The
// converted word is registered and returned together with the requester's id.
//   iw_clk, iw_rst          : clock (rising edge), async active-high reset
//   iwv_req_valid/dir/code  : per-requester request; code k at [k*p_WIDTH +: p_WIDTH]
//   owv_req_ready           : one-hot grant, or all zero
//   ow_rsp_valid/owv_rsp_code/owv_rsp_id/ow_rsp_dir : registered response
//   iw_rsp_ready            : consumer takes the response
module rbc_conv_arbiter
  import rbc_conv_arbiter_pkg::*;
#(
  parameter  int p_WIDTH = 4,
  parameter  int p_PORTS = 3,
  localparam int p_ID_W  = id_width(p_PORTS)
) (
  input  logic                       iw_clk,
  input  logic                       iw_rst,
  input  logic [p_PORTS-1:0]         iwv_req_valid,
  input  logic [p_PORTS-1:0]         iwv_req_dir,
  input  logic [p_PORTS*p_WIDTH-1:0] iwv_req_code,
  output logic [p_PORTS-1:0]         owv_req_ready,
  output logic                       ow_rsp_valid,
  output logic [p_WIDTH-1:0]         owv_rsp_code,
  output logic [p_ID_W-1:0]          owv_rsp_id,
  output logic                       ow_rsp_dir,
  input  logic                       iw_rsp_ready
);

  logic               rsp_valid_q, rsp_valid_d;
  logic [p_WIDTH-1:0] rsp_code_q,  rsp_code_d;
  logic [p_ID_W-1:0]  rsp_id_q,    rsp_id_d;
  logic               rsp_dir_q,   rsp_dir_d;
  logic [p_ID_W-1:0]  ptr_q,       ptr_d;

  logic               slot_free;
  logic               grant_en;
  logic [p_PORTS-1:0] grant;
  logic [p_ID_W-1:0]  grant_idx;
  logic               any_grant;
  logic [p_WIDTH-1:0] sel_code;
  logic               sel_dir;
  logic [p_WIDTH-1:0] to_bin;
  logic [p_WIDTH-1:0] to_rbc;
  logic [p_WIDTH-1:0] conv_code;

  // The slot can take a new word when it is empty or is being drained this
  // cycle. Reset gates the grant so no requester sees ready while the
  // response register is held clear.
  assign slot_free = !rsp_valid_q || iw_rsp_ready;
  assign grant_en  = slot_free && !iw_rst;

  rr_grant #(
    .p_PORTS (p_PORTS),
    .p_ID_W  (p_ID_W)
  ) u_rr_grant (
    .valid_i (iwv_req_valid),
    .ptr_i   (ptr_q),
    .en_i    (grant_en),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (any_grant)
  );

  // The one-hot grant drives an AND-OR mux, so every part-select index is a
  // constant after unrolling.
  always_comb begin
    sel_code = '0;
    sel_dir  = 1'b0;
    for (int i = 0; i < p_PORTS; i++) begin
      if (grant[i]) begin
        sel_code = iwv_req_code[i*p_WIDTH +: p_WIDTH];
        sel_dir  = iwv_req_dir[i];
      end
    end
  end

  rbc2bin #(.p_WIDTH(p_WIDTH)) u_rbc2bin (.rbc_i(sel_code), .bin_o(to_bin));
  bin2rbc #(.p_WIDTH(p_WIDTH)) u_bin2rbc (.bin_i(sel_code), .rbc_o(to_rbc));

  assign conv_code = (sel_dir == DIR_BIN2RBC) ? to_rbc : to_bin;

  // An accept loads the slot and moves the pointer past the winner. A drain
  // with no accept only clears valid. The data stays put, so it is still
  // readable afterwards.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_code_d  = rsp_code_q;
    rsp_id_d    = rsp_id_q;
    rsp_dir_d   = rsp_dir_q;
    ptr_d       = ptr_q;
    if (any_grant) begin
      rsp_valid_d = 1'b1;
      rsp_code_d  = conv_code;
      rsp_id_d    = grant_idx;
      rsp_dir_d   = sel_dir;
      ptr_d       = (grant_idx == p_ID_W'(p_PORTS - 1)) ? '0 : grant_idx + p_ID_W'(1);
    end else if (iw_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= '0;
      rsp_id_q    <= '0;
      rsp_dir_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_id_q    <= rsp_id_d;
      rsp_dir_q   <= rsp_dir_d;
      ptr_q       <= ptr_d;
    end
  end

  assign owv_req_ready = grant;
  assign ow_rsp_valid  = rsp_valid_q;
  assign owv_rsp_code  = rsp_code_q;
  assign owv_rsp_id    = rsp_id_q;
  assign ow_rsp_dir    = rsp_dir_q;

endmodule
